// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a request/ready instruction memory,
// and holds the IF/ID pipeline register with redirect, stall and flush handling.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_func,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HELD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] plus4_q, plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_inc;
    logic [31:0] jmp_addr;

    assign pc_inc   = pc_q + 32'd4;
    assign jmp_addr = jump_target & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        plus4_d = plus4_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (pc_jump) pc_d = jmp_addr;
            end
            S_REQ: begin
                if (pc_jump) begin
                    // The redirect waits in tgt_q while a stale response is
                    // outstanding, so imem_addr stays stable for the memory.
                    if (imem_ready) begin
                        pc_d = jmp_addr;
                    end else begin
                        tgt_d   = jmp_addr;
                        state_d = S_DROP;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (stall && !flush) begin
                        buf_d   = imem_rdata;
                        state_d = S_HELD;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        plus4_d = pc_inc;
                    end
                end else if (!stall || flush) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            end
            S_HELD: begin
                if (pc_jump) begin
                    pc_d    = jmp_addr;
                    state_d = S_REQ;
                end else if (!stall || flush) begin
                    instr_d = buf_q;
                    valid_d = 1'b1;
                    plus4_d = pc_q;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (pc_jump) tgt_d = jmp_addr;
                if (imem_ready) begin
                    pc_d    = tgt_d;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pc_jump || flush) begin
            instr_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            tgt_q   <= '0;
            buf_q   <= '0;
            instr_q <= '0;
            plus4_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            plus4_q <= plus4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem_addr   = pc_q & 32'hFFFF_FFFC;
    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc_plus4 = plus4_q;
    assign id_opcode   = instr_q[31:26];
    assign id_func     = instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// checked against an instruction-stream reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, pc_jump, imem_ready;
    logic [31:0] jump_target, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_instr, id_pc_plus4;
    logic [5:0]  id_opcode, id_func;
    logic        ovr_en;
    logic [31:0] ovr_val;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_plus4;
    logic [5:0]  w_opcode, w_func;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = ovr_en ? ovr_val : word(imem_addr);
    assign w_rdata    = word(w_addr);

    if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .pc_jump(pc_jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_func(id_func), .id_pc_plus4(id_pc_plus4)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0),
        .pc_jump(1'b0), .jump_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rdata(w_rdata),
        .id_valid(w_valid), .id_instr(w_instr), .id_opcode(w_opcode),
        .id_func(w_func), .id_pc_plus4(w_plus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; pc_jump = 1'b0; jump_target = '0;
        imem_ready = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    endtask

    task automatic start();
        idle_inputs();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_plus4: got %h want 0", id_pc_plus4); end
        checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h want fffffff8", w_addr); end
    endtask

    task automatic test_seq();
        start();
        imem_ready = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_idle_req: got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL seq_first_valid: got %b want 0", id_valid); end
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            checks++; if (id_valid !== 1'b1 || id_instr !== word(i * 4)) begin errors++; $display("FAIL seq_instr%0d: got %b/%h want 1/%h", i, id_valid, id_instr, word(i * 4)); end
            checks++; if (id_pc_plus4 !== i * 4 + 4) begin errors++; $display("FAIL seq_plus4_%0d: got %h want %h", i, id_pc_plus4, i * 4 + 4); end
            checks++; if (imem_addr !== i * 4 + 4) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, i * 4 + 4); end
        end
    endtask

    task automatic test_opcode();
        start();
        imem_ready = 1'b1; ovr_en = 1'b1; ovr_val = 32'h0000_0020;
        tick(); tick();
        checks++; if (id_instr !== 32'h20 || id_opcode !== 6'h00 || id_func !== 6'h20) begin errors++; $display("FAIL opc_add: got %h/%h/%h want 20/00/20", id_instr, id_opcode, id_func); end
        ovr_val = 32'h8C00_0015;
        tick();
        checks++; if (id_opcode !== 6'h23 || id_func !== 6'h15) begin errors++; $display("FAIL opc_lw: got %h/%h want 23/15", id_opcode, id_func); end
        ovr_en = 1'b0;
    endtask

    task automatic test_wait();
        start();
        imem_ready = 1'b1;
        tick(); tick(); tick();
        imem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL wait_addr%0d: got req=%b addr=%h want 1/8", i, imem_req, imem_addr); end
            checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL wait_bubble%0d: got %b/%h want 0/0", i, id_valid, id_instr); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b1 || id_instr !== word(32'h8) || id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL wait_resume: got %b/%h/%h want 1/%h/c", id_valid, id_instr, id_pc_plus4, word(32'h8)); end
        tick();
        checks++; if (id_instr !== word(32'hC)) begin errors++; $display("FAIL wait_next: got %h want %h", id_instr, word(32'hC)); end
    endtask

    task automatic test_stall();
        start();
        imem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        stall = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || id_instr !== word(32'h8) || id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL stall_held: got req=%b %h/%h want 0/%h/c", imem_req, id_instr, id_pc_plus4, word(32'h8)); end
        imem_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_instr !== word(32'h8)) begin errors++; $display("FAIL stall_hold2: got req=%b %b/%h want 0/1/%h", imem_req, id_valid, id_instr, word(32'h8)); end
        stall = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_instr !== word(32'hC) || id_pc_plus4 !== 32'h10) begin errors++; $display("FAIL stall_release: got %b/%h/%h want 1/%h/10", id_valid, id_instr, id_pc_plus4, word(32'hC)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_next_addr: got %b/%h want 1/10", imem_req, imem_addr); end
        imem_ready = 1'b1;
        tick();
        checks++; if (id_instr !== word(32'h10)) begin errors++; $display("FAIL stall_after: got %h want %h", id_instr, word(32'h10)); end
    endtask

    task automatic test_jump_pending();
        start();
        imem_ready = 1'b1;
        for (int unsigned i = 0; i < 6; i++) tick();
        imem_ready = 1'b0; pc_jump = 1'b1; jump_target = 32'h0000_0103;
        tick();
        pc_jump = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL jp_squash: got %b/%h want 0/0", id_valid, id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL jp_stable: got %b/%h want 1/14", imem_req, imem_addr); end
        tick();
        imem_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jp_discard: got valid %b want 0", id_valid); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jp_target: got %h want 100", imem_addr); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_instr !== word(32'h100) || id_pc_plus4 !== 32'h104) begin errors++; $display("FAIL jp_first: got %b/%h/%h want 1/%h/104", id_valid, id_instr, id_pc_plus4, word(32'h100)); end
    endtask

    task automatic test_jump_stall_flush();
        start();
        imem_ready = 1'b1;
        tick(); tick(); tick();
        pc_jump = 1'b1; stall = 1'b1; jump_target = 32'h0000_0200;
        tick();
        pc_jump = 1'b0; stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL js_squash: got %b/%h want 0/0", id_valid, id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL js_redirect: got %b/%h want 1/200", imem_req, imem_addr); end
        tick();
        checks++; if (id_instr !== word(32'h200)) begin errors++; $display("FAIL js_first: got %h want %h", id_instr, word(32'h200)); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL fl_squash: got %b/%h want 0/0", id_valid, id_instr); end
        checks++; if (imem_addr !== 32'h208) begin errors++; $display("FAIL fl_pc_continues: got %h want 208", imem_addr); end
        tick();
        checks++; if (id_instr !== word(32'h208) || id_pc_plus4 !== 32'h20C) begin errors++; $display("FAIL fl_next: got %h/%h want %h/20c", id_instr, id_pc_plus4, word(32'h208)); end
    endtask

    task automatic test_reset_mid();
        start();
        imem_ready = 1'b1;
        tick(); tick(); tick();
        imem_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_fetch: got %b/%h want 0/0", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rmid_ifid: got %b/%h/%h want 0/0/0", id_valid, id_instr, id_pc_plus4); end
    endtask

    task automatic test_wrap();
        start();
        tick();
        checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0: got %b/%h want 1/fffffff8", w_req, w_addr); end
        tick();
        checks++; if (w_instr !== word(32'hFFFF_FFF8) || w_plus4 !== 32'hFFFF_FFFC || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1: got %h/%h/%h want %h/fffffffc/fffffffc", w_instr, w_plus4, w_addr, word(32'hFFFF_FFF8)); end
        tick();
        checks++; if (w_instr !== word(32'hFFFF_FFFC) || w_plus4 !== 32'h0 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_a2: got %h/%h/%h want %h/0/0", w_instr, w_plus4, w_addr, word(32'hFFFF_FFFC)); end
        checks++; if (w_valid !== 1'b1 || w_opcode !== 6'h16 || w_func !== 6'h3C) begin errors++; $display("FAIL wrap_fields: got %b/%h/%h want 1/16/3c", w_valid, w_opcode, w_func); end
        tick();
        checks++; if (w_instr !== word(32'h0) || w_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_a3: got %h/%h want %h/4", w_instr, w_plus4, word(32'h0)); end
    endtask

    // Reference model: ID must see the program stream in order from the last
    // redirect target, with stalls freezing IF/ID and redirects squashing it.
    task automatic test_random();
        logic [31:0] exp_pc, p_instr, p_plus4, p_addr, jt;
        logic        p_valid, p_req, j, s, r;
        int          delivered;
        delivered = 0;
        start();
        tick();
        exp_pc = 32'h0;
        for (int unsigned n = 0; n < 600; n++) begin
            r  = ($urandom_range(3) != 0);
            s  = ($urandom_range(4) == 0);
            j  = ($urandom_range(19) == 0);
            jt = $urandom;
            imem_ready = r; stall = s; pc_jump = j; jump_target = jt;
            p_valid = id_valid; p_instr = id_instr; p_plus4 = id_pc_plus4;
            p_addr = imem_addr; p_req = imem_req;
            tick();
            if (p_req && !r) begin
                checks++; if (imem_addr !== p_addr) begin errors++; $display("FAIL rnd_addr_stable@%0d: got %h want %h", n, imem_addr, p_addr); end
            end
            if (j) begin
                checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL rnd_jump_squash@%0d: got %b/%h want 0/0", n, id_valid, id_instr); end
                exp_pc = jt & 32'hFFFF_FFFC;
            end else if (s) begin
                checks++; if (id_valid !== p_valid || id_instr !== p_instr || id_pc_plus4 !== p_plus4) begin errors++; $display("FAIL rnd_stall_hold@%0d: got %b/%h/%h want %b/%h/%h", n, id_valid, id_instr, id_pc_plus4, p_valid, p_instr, p_plus4); end
            end else if (id_valid) begin
                checks++; if (id_instr !== word(exp_pc) || id_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_stream@%0d: got %h/%h want %h/%h", n, id_instr, id_pc_plus4, word(exp_pc), exp_pc + 32'd4); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rnd_bubble@%0d: got %h want 0", n, id_instr); end
            end
            checks++; if (id_opcode !== id_instr[31:26] || id_func !== id_instr[5:0]) begin errors++; $display("FAIL rnd_fields@%0d: got %h/%h for %h", n, id_opcode, id_func, id_instr); end
        end
        idle_inputs();
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d instructions want >= 100", delivered); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_seq();
        test_opcode();
        test_wait();
        test_stall();
        test_jump_pending();
        test_jump_stall_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It produces the instruction word whose opcode and func fields feed the instruction decoder in ID.
- Owns the PC and drives a variable-latency instruction-memory request/ready interface.
- Applies the decoder's jump request (PC_jump with a target register value) as a redirect.
- Honours the stall and flush inputs from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold the IF/ID register and PC
- flush  input  1  squash the IF/ID contents (insert NOP bubble)
- pc_jump  input  1  redirect request from the ID-stage decoder
- jump_target  input  32  redirect address; bits [1:0] ignored
- imem_req  output  1  instruction-memory request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word
- id_valid  output  1  IF/ID holds a real instruction
- id_instr  output  32  IF/ID instruction (32'h0000_0000 = NOP when invalid)
- id_opcode  output  6  id_instr[31:26]
- id_func  output  6  id_instr[5:0]
- id_pc_plus4  output  32  address of the fetched instruction + 4

Behaviour:
- Reset (asynchronous, any state, including mid-request):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - id_valid=0, id_instr=0, id_pc_plus4=0, holding buffer empty.
  - An outstanding memory response is forgotten. Memory must tolerate abandonment on reset.
- imem_addr always equals {pc[31:2],2'b00}. It is stable while imem_req=1 and imem_ready=0.
- States:
  - IDLE: imem_req=0. Moves to REQ on the next cycle after reset release.
  - REQ: imem_req=1. Waits for imem_ready.
  - HELD: imem_req=0. The response arrived during a stall and sits in a one-entry buffer.
  - DROP: imem_req=1 at the old address. The outstanding response must be discarded.
- Priority per cycle: redirect (pc_jump or flush) > stall > normal fetch.
- REQ, imem_ready=1, stall=0, no redirect:
  - id_instr<=imem_rdata, id_valid<=1, id_pc_plus4<=pc+4, pc<=pc+4.
  - Stay in REQ; the next request is issued back-to-back. Throughput is 1 instr/cycle with zero wait states.
- REQ, imem_ready=1, stall=1:
  - buffer<=imem_rdata, pc<=pc+4, go to HELD. IF/ID is unchanged.
- REQ, imem_ready=0:
  - If stall=0, id_valid<=0 and id_instr<=0 (bubble).
  - If stall=1, IF/ID holds.
- HELD, stall=0: IF/ID <= buffer, with id_pc_plus4 = current pc. Go to REQ.
- HELD, stall=1: hold everything.
- Redirect, pc_jump=1:
  - pc<={jump_target[31:2],2'b00}.
  - IF/ID squashed (id_valid<=0, id_instr<=0). This applies even when stall=1.
  - From REQ with imem_ready=1: discard data, go to REQ at the new pc next cycle.
  - From REQ with imem_ready=0: go to DROP.
  - From HELD: discard the buffer, go to REQ.
  - From IDLE: load pc, go to REQ.
- flush=1 without pc_jump: IF/ID squashed only. The pc and fetch state machine proceed as if stall=0, except that data captured this cycle goes to IF/ID as NOP. Use the squash-only case.
- DROP:
  - On imem_ready=1, discard the data and go to REQ with imem_addr = redirected pc.
  - A further pc_jump in DROP overwrites the pc; the state stays DROP.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- id_opcode and id_func are combinational slices of id_instr.

Test Plan:
- Sequential fetch:
  - Stimulus: release reset; memory always ready; rdata = addr ^ 32'hA5A5_0000.
  - Response: imem_addr 0,4,8,… from cycle 2; id_instr follows one cycle later; id_pc_plus4 = addr+4.
  - At id_instr=32'h0000_0020 (ADD func), id_opcode=0 and id_func=6'h20.
- Wait states:
  - Stimulus: imem_ready low for 3 cycles at addr 8.
  - Response: imem_addr held at 8; id_valid=0 for 3 cycles; then the instruction at 8 appears; no instruction skipped or duplicated.
- Stall during response:
  - Stimulus: stall=1 for 2 cycles on the cycle imem_ready=1 at addr 12.
  - Response: state HELD; IF/ID unchanged; on release, the word from addr 12 appears; the next imem_addr is 16.
- Jump during a pending request:
  - Stimulus: pc_jump=1, jump_target=32'h0000_0103, while waiting at addr 20; imem_ready comes 2 cycles later.
  - Response: that response is discarded; the next request is at 32'h0000_0100; id_valid stays 0 until the 32'h100 instruction arrives.
- Jump beats stall, plus flush:
  - Stimulus: pc_jump=1 and stall=1 in the same cycle; separately, a lone flush.
  - Response: IF/ID squashed and pc redirected in both cases where pc_jump is set; the lone flush squashes only and the pc continues.
- Reset mid-request and wrap:
  - Stimulus: assert rst_n low asynchronously mid-REQ; separately, RESET_PC=32'hFFFF_FFF8.
  - Response: outputs take reset values immediately; the second case fetches FFF8, FFFC, then 0000_0000.
